pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register with a two-entry
// skid buffer (main + skid), flush, and a bubble value on out_ctrl when idle.
// in_ready and out_valid come straight from flops, so there is no
// combinational path from out_ready to in_ready.
// Optional feature: define PIPE_STAGE_PERF_EN to build the saturating
// stall_cycles counter; otherwise stall_cycles is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no valid beat held, out_valid=0, in_ready=1
// ST_ONE   | main entry valid, out_valid=1, in_ready=1
// ST_FULL  | main and skid valid, out_valid=1, in_ready=0

module pipe_stage_reg #(
    parameter int unsigned        CTRL_W      = 16,
    parameter int unsigned        DATA_W      = 128,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_accept;
    logic w_drain;
    logic w_load_main_in;
    logic w_load_skid;
    logic w_move_skid;

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    // Next-state and entry-load decode; flush overrides everything and
    // suppresses loads so out_data keeps its last value while empty.
    always_comb begin
        w_state_nxt    = r_state;
        w_load_main_in = 1'b0;
        w_load_skid    = 1'b0;
        w_move_skid    = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_move_skid = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus the registered handshake outputs derived from it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Main entry: loads from the input or from the skid entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_move_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
        end
    end

    // Skid entry: captures the one extra beat accepted while main is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_valid ? r_main_ctrl : CTRL_BUBBLE;
    assign out_data  = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cycles;

    // Count cycles where a beat is offered but downstream refuses it; saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. Inputs change 1 time unit after the
// rising edge; outputs are checked after the edge has settled.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 128;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       stall_cycles;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CTRL_BUBBLE(16'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ctrl(in_ctrl),
        .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl(out_ctrl),
        .out_data(out_data),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_ctrl !== 16'h0000 || out_data !== 128'h0 || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_values: ctrl=%h data=%h stall=%0d, need 0/0/0", out_ctrl, out_data, stall_cycles);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        in_ctrl   = 16'h00A5;
        in_data   = 128'h1234;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL single_before: out_valid=%b ctrl=%h, need 0/0000", out_valid, out_ctrl);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h00A5 || out_data !== 128'h1234) begin
            failures++;
            $display("FAIL single_after: valid=%b ctrl=%h data=%h, need 1/00a5/1234", out_valid, out_ctrl, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0000 || out_data !== 128'h1234) begin
            failures++;
            $display("FAIL single_drained: valid=%b ctrl=%h data=%h, need 0/0000/1234", out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 16'h0100 + 16'(i);
            in_data  = 128'(i * 3 + 7);
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
                out_ctrl !== 16'h0100 + 16'(i) || out_data !== 128'(i * 3 + 7)) begin
                failures++;
                $display("FAIL b2b_beat%0d: valid=%b rdy=%b ctrl=%h data=%h, need 1/1/%h/%h",
                         i, out_valid, in_ready, out_ctrl, out_data, 16'h0100 + 16'(i), 128'(i * 3 + 7));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: out_valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h0A0A;
        in_data   = 128'hAAAA;
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_ctrl !== 16'h0A0A) begin
            failures++;
            $display("FAIL skid_one: valid=%b rdy=%b ctrl=%h, need 1/1/0a0a", out_valid, in_ready, out_ctrl);
        end
        in_ctrl = 16'h0B0B;
        in_data = 128'hBBBB;
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_ctrl !== 16'h0A0A) begin
            failures++;
            $display("FAIL skid_full: valid=%b rdy=%b ctrl=%h, need 1/0/0a0a", out_valid, in_ready, out_ctrl);
        end
        in_ctrl = 16'h0C0C;
        in_data = 128'hCCCC;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_ctrl !== 16'h0A0A || out_data !== 128'hAAAA) begin
            failures++;
            $display("FAIL skid_hold: rdy=%b ctrl=%h data=%h, need 0/0a0a/aaaa", in_ready, out_ctrl, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_ctrl !== 16'h0B0B || out_data !== 128'hBBBB) begin
            failures++;
            $display("FAIL skid_drain1: valid=%b rdy=%b ctrl=%h data=%h, need 1/1/0b0b/bbbb",
                     out_valid, in_ready, out_ctrl, out_data);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h0C0C || out_data !== 128'hCCCC) begin
            failures++;
            $display("FAIL skid_drain2: valid=%b ctrl=%h data=%h, need 1/0c0c/cccc", out_valid, out_ctrl, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL skid_empty: valid=%b rdy=%b, need 0/1", out_valid, in_ready);
        end
    endtask

    task automatic fill_full(input logic [15:0] c0, input logic [15:0] c1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = c0;
        in_data   = {112'h0, c0};
        step();
        in_ctrl   = c1;
        in_data   = {112'h0, c1};
        step();
        in_valid  = 1'b0;
    endtask

    task automatic test_flush();
        fill_full(16'h0D0D, 16'h0E0E);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 16'h0F0F;
        in_data  = 128'hFFFF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0000 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state: valid=%b ctrl=%h rdy=%b, need 0/0000/1", out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0D0D) begin
            failures++;
            $display("FAIL flush_after: valid=%b data=%h, need 0/0d0d", out_valid, out_data);
        end
    endtask

    task automatic test_async_reset();
        fill_full(16'h1111, 16'h2222);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 16'h0000 ||
            out_data !== 128'h0 || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: valid=%b rdy=%b ctrl=%h data=%h stall=%0d, need 0/1/0/0/0",
                     out_valid, in_ready, out_ctrl, out_data, stall_cycles);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_resume_idle: valid=%b rdy=%b, need 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h3333;
        in_data   = 128'h3333;
        step();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h3333 || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL stall_start: valid=%b ctrl=%h stall=%0d, need 1/3333/0", out_valid, out_ctrl, stall_cycles);
        end
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1;
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (stall_cycles !== 32'd5) begin
            failures++;
            $display("FAIL stall_count: stall=%0d, need 5", stall_cycles);
        end
        step();
        checks++;
        if (stall_cycles !== 32'd5 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_after_drain: stall=%0d valid=%b, need 5/0", stall_cycles, out_valid);
        end
`else
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL stall_count: stall=%0d, need 0", stall_cycles);
        end
        step();
        checks++;
        if (stall_cycles !== 32'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_after_drain: stall=%0d valid=%b, need 0/0", stall_cycles, out_valid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_skid();
        test_flush();
        test_async_reset();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
